// File: rtl/uart_apb_bridge.sv
// -----------------------------------------------------------------------------
// uart_apb_bridge
//
// APB3 slave that is the only bus master of uart_protocol. It converts APB
// transfers into single-cycle TX FIFO pushes and RX FIFO pops, returns the
// FIFO head and the status words on reads, and owns the interrupt enable (IER)
// and sticky interrupt status (ISR) registers that drive the irq line.
//
// Register map (byte addresses):
//   0x00 TXDATA  W     push pwdata[DATA_SIZE-1:0] into the TX FIFO
//   0x04 RXDATA  R     pop the RX FIFO head (one wait state)
//   0x08 TXSTAT  R     TX_status_register, zero-extended
//   0x0C RXSTAT  R     RX_status_register, zero-extended
//   0x10 IER     RW    [2:0] interrupt enables
//   0x14 ISR     R/W1C [2:0] {rx_error, tx_drained, rx_data}
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   psel, penable,
//   pwrite, paddr,
//   pwdata               APB request
//   prdata, pready,
//   pslverr              APB response (combinational from the FSM state)
//   write_data           1-cycle TX FIFO push, data on bus_data_in
//   read_data            1-cycle RX FIFO pop, head arrives on bus_data_out
//   TX_status_register   {5'b0, tx_done, tx_empty, tx_full}
//   RX_status_register   {1'b0, rx_done, ovf, stop, brk, par, rx_empty, rx_full}
//   irq                  registered level interrupt, |(ISR & IER)
// -----------------------------------------------------------------------------
module uart_apb_bridge #(
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  write_data,
  output logic [DATA_SIZE-1:0]  bus_data_in,
  output logic                  read_data,
  input  logic [DATA_SIZE-1:0]  bus_data_out,
  input  logic [7:0]            TX_status_register,
  input  logic [7:0]            RX_status_register,
  output logic                  irq
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RDWAIT = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] ADDR_TXDATA = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RXDATA = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TXSTAT = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RXSTAT = ADDR_WIDTH'(8'h0C);
  localparam logic [ADDR_WIDTH-1:0] ADDR_IER    = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ISR    = ADDR_WIDTH'(8'h14);

  logic [1:0]           r_state;
  logic [DATA_SIZE-1:0] r_rx_data;
  logic [2:0]           r_ier;
  logic [2:0]           r_isr;
  logic                 r_irq;
  logic                 r_tx_empty_d;
  logic                 r_rx_empty_d;
  logic                 r_err_d;

  logic [1:0]  w_next_state;
  logic [31:0] w_prdata;
  logic        w_pready;
  logic        w_pslverr;
  logic        w_write_data;
  logic        w_read_data;
  logic        w_ier_we;
  logic        w_isr_we;
  logic [2:0]  w_isr_set;
  logic [2:0]  w_isr_clr;

  logic w_tx_full;
  logic w_tx_empty;
  logic w_rx_empty;
  logic w_rx_err;

  assign w_tx_full  = TX_status_register[0];
  assign w_tx_empty = TX_status_register[1];
  assign w_rx_empty = RX_status_register[1];
  assign w_rx_err   = |RX_status_register[5:2];

  // ---------------------------------------------------------------------------
  // Transfer FSM and response decode. Responses are combinational from the
  // registered state so every transfer except an RXDATA pop completes with
  // zero wait states. The pop needs one wait state because the FIFO head is
  // captured on the edge that ends the ACCESS cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_next_state = r_state;
    w_prdata     = '0;
    w_pready     = 1'b0;
    w_pslverr    = 1'b0;
    w_write_data = 1'b0;
    w_read_data  = 1'b0;
    w_ier_we     = 1'b0;
    w_isr_we     = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (psel && !penable) begin
          w_next_state = S_ACCESS;
        end
      end

      S_ACCESS: begin
        // psel dropped mid-transfer: abandon it silently.
        w_next_state = S_IDLE;
        if (psel) begin
          w_pready = 1'b1;
          if (pwrite) begin
            case (paddr)
              ADDR_TXDATA: begin
                // A full FIFO drops the byte and reports an error.
                if (w_tx_full) w_pslverr    = 1'b1;
                else           w_write_data = 1'b1;
              end
              ADDR_IER: w_ier_we  = 1'b1;
              ADDR_ISR: w_isr_we  = 1'b1;
              default:  w_pslverr = 1'b1;
            endcase
          end else begin
            case (paddr)
              ADDR_RXDATA: begin
                if (w_rx_empty) begin
                  w_pslverr = 1'b1;
                end else begin
                  w_read_data  = 1'b1;
                  w_pready     = 1'b0;
                  w_next_state = S_RDWAIT;
                end
              end
              ADDR_TXSTAT: w_prdata  = {24'h0, TX_status_register};
              ADDR_RXSTAT: w_prdata  = {24'h0, RX_status_register};
              ADDR_IER:    w_prdata  = {29'h0, r_ier};
              ADDR_ISR:    w_prdata  = {29'h0, r_isr};
              default:     w_pslverr = 1'b1;
            endcase
          end
        end
      end

      S_RDWAIT: begin
        w_next_state = S_IDLE;
        if (psel) begin
          w_pready = 1'b1;
          w_prdata = 32'(r_rx_data);
        end
      end

      default: w_next_state = S_IDLE;
    endcase
  end

  // Sticky interrupt sources: each fires on a 0->1 event relative to the
  // previous cycle's value. A set in the same cycle as a W1C wins.
  assign w_isr_set = {~r_err_d & w_rx_err,
                      ~r_tx_empty_d & w_tx_empty,
                      r_rx_empty_d & ~w_rx_empty};
  assign w_isr_clr = w_isr_we ? pwdata[2:0] : 3'b000;

  // ---------------------------------------------------------------------------
  // State. Edge-detect flops reset to the idle FIFO condition (both empty,
  // no error) so leaving reset does not raise a spurious event.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_rx_data    <= '0;
      r_ier        <= 3'b000;
      r_isr        <= 3'b000;
      r_irq        <= 1'b0;
      r_tx_empty_d <= 1'b1;
      r_rx_empty_d <= 1'b1;
      r_err_d      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      r_state      <= w_next_state;
      r_tx_empty_d <= w_tx_empty;
      r_rx_empty_d <= w_rx_empty;
      r_err_d      <= w_rx_err;
      r_isr        <= (r_isr & ~w_isr_clr) | w_isr_set;
      r_irq        <= |(r_isr & r_ier);
      if (w_read_data) r_rx_data <= bus_data_out;
      if (w_ier_we)    r_ier     <= pwdata[2:0];
    end
  end

  assign prdata      = w_prdata;
  assign pready      = w_pready;
  assign pslverr     = w_pslverr;
  assign write_data  = w_write_data;
  assign read_data   = w_read_data;
  assign bus_data_in = pwdata[DATA_SIZE-1:0];
  assign irq         = r_irq;

  // Status bits and upper write-data bits this bridge does not interpret.
  logic w_unused;
  assign w_unused = &{1'b0, TX_status_register, RX_status_register, pwdata};

endmodule
